// File: rtl/mfa_seq_ctrl.sv
// Index-compression sequencer: buffers one block while feeding an MFA detector,
// then emits header (MFA value), match bitmap and the unmatched words in order.
module mfa_seq_ctrl #(
  parameter int WIDTH_DATA = 32,
  parameter int BLOCK_LEN  = 8,
  parameter int LOG_BLOCK  = $clog2(BLOCK_LEN),
  parameter int MFA_CNT_W  = 3,
  parameter int MIN_COUNT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Valid,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Ready,
  output logic                  O_MFA_Valid,
  output logic [WIDTH_DATA-1:0] O_MFA_Data,
  output logic                  O_MFA_FValid,
  output logic [WIDTH_DATA-1:0] O_MFA_FData,
  output logic                  O_MFA_Rd,
  input  logic                  I_MFA_Valid,
  input  logic [WIDTH_DATA-1:0] I_MFA_Data,
  input  logic [MFA_CNT_W-1:0]  I_MFA_Count,
  output logic                  O_Valid,
  output logic [WIDTH_DATA-1:0] O_Data,
  output logic                  O_Last,
  input  logic                  I_Ready,
  output logic                  O_Busy
);

  typedef enum logic [2:0] {IDLE, LOAD, RD, CAPT, HDR, MSK, DAT} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_DATA-1:0] mem_q [BLOCK_LEN];
  logic [WIDTH_DATA-1:0] mem_d [BLOCK_LEN];
  logic [LOG_BLOCK-1:0]  wr_idx_q, wr_idx_d;
  logic [LOG_BLOCK-1:0]  rd_idx_q, rd_idx_d;
  logic [WIDTH_DATA-1:0] mfa_val_q, mfa_val_d;
  logic [MFA_CNT_W-1:0]  mfa_cnt_q, mfa_cnt_d;
  logic                  mfa_vld_q, mfa_vld_d;

  logic                  use_c;
  logic [BLOCK_LEN-1:0]  mask;
  logic [LOG_BLOCK-1:0]  first_idx;
  logic [LOG_BLOCK-1:0]  next_idx;
  logic                  has_next;
  logic                  feed;

  assign use_c = mfa_vld_q && (mfa_cnt_q >= MFA_CNT_W'(MIN_COUNT));

  // Lowest unmasked index overall and lowest unmasked index above rd_idx,
  // so masked entries are skipped without bubbles.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      mask[i] = use_c && (mem_q[i] == mfa_val_q);
    end
    for (int i = BLOCK_LEN - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        first_idx = LOG_BLOCK'(i);
        if (LOG_BLOCK'(i) > rd_idx_q) begin
          next_idx = LOG_BLOCK'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    mfa_val_d = mfa_val_q;
    mfa_cnt_d = mfa_cnt_q;
    mfa_vld_d = mfa_vld_q;
    O_Ready   = 1'b0;
    O_Valid   = 1'b0;
    O_Data    = '0;
    O_Last    = 1'b0;
    O_MFA_Rd  = 1'b0;

    case (state_q)
      IDLE: begin
        O_Ready = 1'b1;
        if (I_Valid) begin
          mem_d[0] = I_Data;
          wr_idx_d = LOG_BLOCK'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        O_Ready = 1'b1;
        if (I_Valid) begin
          mem_d[wr_idx_q] = I_Data;
          wr_idx_d        = wr_idx_q + LOG_BLOCK'(1);
          if (wr_idx_q == LOG_BLOCK'(BLOCK_LEN - 1)) state_d = RD;
        end
      end
      RD: begin
        O_MFA_Rd = 1'b1;
        state_d  = CAPT;
      end
      CAPT: begin
        mfa_val_d = I_MFA_Data;
        mfa_cnt_d = I_MFA_Count;
        mfa_vld_d = I_MFA_Valid;
        state_d   = HDR;
      end
      HDR: begin
        O_Valid = 1'b1;
        O_Data  = use_c ? mfa_val_q : '0;
        if (I_Ready) state_d = MSK;
      end
      MSK: begin
        O_Valid                = 1'b1;
        O_Data[BLOCK_LEN-1:0]  = mask;
        O_Last                 = &mask;
        if (I_Ready) begin
          if (&mask) begin
            state_d = IDLE;
          end else begin
            rd_idx_d = first_idx;
            state_d  = DAT;
          end
        end
      end
      DAT: begin
        O_Valid = 1'b1;
        O_Data  = mem_q[rd_idx_q];
        O_Last  = !has_next;
        if (I_Ready) begin
          if (has_next) rd_idx_d = next_idx;
          else          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs read as zero while reset is held.
    if (reset) begin
      O_Ready  = 1'b0;
      O_Valid  = 1'b0;
      O_Data   = '0;
      O_Last   = 1'b0;
      O_MFA_Rd = 1'b0;
    end

    feed         = I_Valid && O_Ready;
    O_MFA_Valid  = feed;
    O_MFA_FValid = feed;
    O_MFA_Data   = feed ? I_Data : '0;
    O_MFA_FData  = feed ? I_Data : '0;
    O_Busy       = (state_q != IDLE) && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      mfa_val_q <= '0;
      mfa_cnt_q <= '0;
      mfa_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      mfa_val_q <= mfa_val_d;
      mfa_cnt_q <= mfa_cnt_d;
      mfa_vld_q <= mfa_vld_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mfa_seq_ctrl.sv
// Scoreboard bench for mfa_seq_ctrl with a behavioural MFA detector model that
// answers reads with the most frequent word of the block it was fed.
module tb_mfa_seq_ctrl;
  localparam int W  = 32;
  localparam int BL = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Valid;
  logic [W-1:0]  I_Data;
  logic          O_Ready;
  logic          O_MFA_Valid;
  logic [W-1:0]  O_MFA_Data;
  logic          O_MFA_FValid;
  logic [W-1:0]  O_MFA_FData;
  logic          O_MFA_Rd;
  logic          I_MFA_Valid;
  logic [W-1:0]  I_MFA_Data;
  logic [CW-1:0] I_MFA_Count;
  logic          O_Valid;
  logic [W-1:0]  O_Data;
  logic          O_Last;
  logic          I_Ready;
  logic          O_Busy;

  mfa_seq_ctrl #(
    .WIDTH_DATA(W), .BLOCK_LEN(BL), .MFA_CNT_W(CW), .MIN_COUNT(2)
  ) dut (
    .clock(clock), .reset(reset), .I_Valid(I_Valid), .I_Data(I_Data),
    .O_Ready(O_Ready), .O_MFA_Valid(O_MFA_Valid), .O_MFA_Data(O_MFA_Data),
    .O_MFA_FValid(O_MFA_FValid), .O_MFA_FData(O_MFA_FData), .O_MFA_Rd(O_MFA_Rd),
    .I_MFA_Valid(I_MFA_Valid), .I_MFA_Data(I_MFA_Data), .I_MFA_Count(I_MFA_Count),
    .O_Valid(O_Valid), .O_Data(O_Data), .O_Last(O_Last), .I_Ready(I_Ready),
    .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  typedef logic [W-1:0] blk_t [BL];
  typedef struct packed { logic [W-1:0] data; logic last; } exp_t;
  typedef struct packed { logic vld; logic force_en; logic [CW-1:0] force_cnt; } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;
  int   xfer_total = 0;
  int   cycle = 0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Most frequent word (first occurrence wins ties), count saturated to the port width.
  function automatic void modeOf(input blk_t b, output logic [W-1:0] v, output logic [CW-1:0] c);
    int best;
    int n;
    best = 0;
    v = '0;
    for (int i = 0; i < BL; i++) begin
      n = 0;
      for (int j = 0; j < BL; j++) if (b[j] == b[i]) n++;
      if (n > best) begin
        best = n;
        v = b[i];
      end
    end
    c = (best > 7) ? CW'(7) : CW'(best);
  endfunction

  task automatic applyStimulus(input blk_t b, input logic vld, input logic force_en,
                               input logic [CW-1:0] force_cnt, input bit hold_valid);
    logic [W-1:0]  v;
    logic [CW-1:0] c;
    logic          use_it;
    logic [W-1:0]  m;
    int            remaining;
    int            waited;
    exp_t          e;
    cfg_t          cfg;
    modeOf(b, v, c);
    if (force_en) c = force_cnt;
    use_it = vld && (c >= CW'(2));
    m = '0;
    remaining = 0;
    for (int i = 0; i < BL; i++) begin
      m[i] = use_it && (b[i] == v);
      if (!m[i]) remaining++;
    end
    e.data = use_it ? v : '0; e.last = 1'b0; exp_q.push_back(e);
    e.data = m; e.last = (remaining == 0); exp_q.push_back(e);
    for (int i = 0; i < BL; i++) begin
      if (!m[i]) begin
        remaining--;
        e.data = b[i]; e.last = (remaining == 0); exp_q.push_back(e);
      end
    end
    cfg.vld = vld; cfg.force_en = force_en; cfg.force_cnt = force_cnt;
    cfg_q.push_back(cfg);
    for (int i = 0; i < BL; i++) begin
      I_Valid = 1'b1;
      I_Data  = b[i];
      waited  = 0;
      forever begin
        @(negedge clock);
        if (O_Ready) break;
        waited++;
        if (waited > 300) begin
          total++; bad++;
          $display("[TB] FAIL load_timeout: word %0d not accepted, O_Ready=%0b wanted 1", i, O_Ready);
          break;
        end
      end
      @(posedge clock); #1;
    end
    if (!hold_valid) begin
      I_Valid = 1'b0;
      I_Data  = $urandom;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() == 0 && !O_Busy) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("[TB] FAIL drain_timeout: %0d words outstanding, wanted 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  // I_Ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    I_Ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       I_Ready = 1'b1;
        1:       I_Ready = ~I_Ready;
        default: I_Ready = 1'($urandom);
      endcase
    end
  end

  // Behavioural MFA unit: records fed words, answers one cycle after a read pulse,
  // drives noise on its outputs at all other times.
  initial begin
    blk_t          hist;
    int            hn;
    int            last_feed;
    bit            pending;
    cfg_t          cur;
    logic [W-1:0]  mv;
    logic [CW-1:0] mc;
    hn = 0; last_feed = 0; pending = 0; mv = '0; mc = '0; cur = '0;
    for (int i = 0; i < BL; i++) hist[i] = '0;
    I_MFA_Valid = 1'b0; I_MFA_Data = '0; I_MFA_Count = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hn = 0; pending = 0; I_MFA_Valid = 1'b0;
        continue;
      end
      if (pending) begin
        I_MFA_Valid = cur.vld; I_MFA_Data = mv; I_MFA_Count = mc;
        pending = 0;
      end else begin
        I_MFA_Valid = 1'($urandom); I_MFA_Data = $urandom; I_MFA_Count = CW'($urandom);
      end
      if (O_MFA_FValid) begin
        checkOutput("feed_valid", W'(O_MFA_Valid), W'(1));
        checkOutput("feed_fdata", O_MFA_FData, I_Data);
        checkOutput("feed_data", O_MFA_Data, I_Data);
        if (hn < BL) hist[hn] = O_MFA_FData;
        hn++;
        last_feed = cycle;
      end
      if (O_MFA_Rd) begin
        checkOutput("feed_count", W'(hn), W'(BL));
        checkOutput("rd_timing", W'(cycle - last_feed), W'(1));
        if (cfg_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL rd_unexpected: read pulse with no block queued, wanted none");
          cur = '0;
        end else begin
          cur = cfg_q.pop_front();
        end
        modeOf(hist, mv, mc);
        if (cur.force_en) mc = cur.force_cnt;
        pending = 1;
        hn = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every downstream transfer.
  initial begin
    bit           emitting;
    bit           stall;
    bit           last_done;
    logic [W-1:0] sd;
    logic         sl;
    int           rd_pulses;
    exp_t         e;
    emitting = 0; stall = 0; last_done = 0; sd = '0; sl = 1'b0; rd_pulses = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        emitting = 0; stall = 0; last_done = 0; rd_pulses = 0;
        continue;
      end
      if (last_done) begin
        checkOutput("busy_after_last", W'(O_Busy), W'(0));
        checkOutput("ready_after_last", W'(O_Ready), W'(1));
        last_done = 0;
      end
      if (stall) begin
        checkOutput("stall_valid", W'(O_Valid), W'(1));
        checkOutput("stall_data", O_Data, sd);
        checkOutput("stall_last", W'(O_Last), W'(sl));
      end
      if (O_MFA_Rd) begin
        rd_pulses++;
        emitting = 1;
      end
      if (emitting) begin
        checkOutput("ready_low_emit", W'(O_Ready), W'(0));
        checkOutput("no_feed_emit", W'(O_MFA_FValid), W'(0));
      end
      stall = O_Valid && !I_Ready;
      sd = O_Data;
      sl = O_Last;
      if (O_Valid && I_Ready) begin
        xfer_total++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL out_extra: unexpected word 0x%0h, wanted none", O_Data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", O_Data, e.data);
          checkOutput("out_last", W'(O_Last), W'(e.last));
        end
        if (O_Last) begin
          checkOutput("rd_pulses", W'(rd_pulses), W'(1));
          rd_pulses = 0;
          emitting = 0;
          last_done = 1;
        end
      end
    end
  end

  initial begin
    blk_t b1;
    blk_t b11;
    blk_t br;
    logic [W-1:0] vals [3];
    int base;
    int n;
    b1[0] = 5; b1[1] = 7; b1[2] = 5; b1[3] = 5; b1[4] = 9; b1[5] = 5; b1[6] = 2; b1[7] = 5;
    for (int i = 0; i < BL; i++) b11[i] = 32'h11;
    reset = 1'b1; I_Valid = 1'b0; I_Data = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_valid", W'(O_Valid), W'(0));
    checkOutput("rst_busy", W'(O_Busy), W'(0));
    checkOutput("rst_rd", W'(O_MFA_Rd), W'(0));
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_ready", W'(O_Ready), W'(1));
    checkOutput("post_rst_valid", W'(O_Valid), W'(0));
    checkOutput("post_rst_last", W'(O_Last), W'(0));
    @(posedge clock); #1;

    $display("[TB] block with MFA 5, count 5");
    ready_mode = 0;
    applyStimulus(b1, 1'b1, 1'b0, '0, 0);
    waitIdle();

    $display("[TB] same block, count below threshold");
    applyStimulus(b1, 1'b1, 1'b1, CW'(1), 0);
    waitIdle();

    $display("[TB] uniform block, mask all ones");
    applyStimulus(b11, 1'b1, 1'b1, CW'(4), 0);
    waitIdle();

    $display("[TB] toggled downstream ready");
    ready_mode = 1;
    applyStimulus(b1, 1'b1, 1'b0, '0, 0);
    waitIdle();

    $display("[TB] reset during data phase");
    ready_mode = 0;
    base = xfer_total;
    applyStimulus(b1, 1'b1, 1'b0, '0, 0);
    n = 0;
    forever begin
      @(posedge clock);
      if (xfer_total >= base + 3) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("[TB] FAIL reset_wait: %0d words emitted, wanted 3", xfer_total - base);
        break;
      end
    end
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_valid", W'(O_Valid), W'(0));
    checkOutput("abort_ready", W'(O_Ready), W'(1));
    checkOutput("abort_mfa_valid", W'(O_MFA_Valid), W'(0));
    checkOutput("abort_mfa_fvalid", W'(O_MFA_FValid), W'(0));
    checkOutput("abort_mfa_rd", W'(O_MFA_Rd), W'(0));
    checkOutput("abort_busy", W'(O_Busy), W'(0));
    @(posedge clock); #1;
    applyStimulus(b1, 1'b1, 1'b0, '0, 0);
    waitIdle();

    $display("[TB] random blocks");
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 3; j++) vals[j] = $urandom;
      for (int i = 0; i < BL; i++) br[i] = vals[$urandom_range(0, 2)];
      applyStimulus(br, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                    CW'($urandom), 0);
      waitIdle();
    end

    $display("[TB] upstream valid held through emission");
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) vals[j] = $urandom;
      for (int i = 0; i < BL; i++) br[i] = vals[$urandom_range(0, 2)];
      applyStimulus(br, 1'b1, 1'b0, '0, (k != 2));
    end
    waitIdle();

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
